// File: rtl/fir_dac_serializer.sv
// Output stage behind fir_n: captures y_out on each sample tick, rescales it with round-half-up
// and saturation, then shifts the word MSB-first to an external DAC over sclk/sdata/frame.
module fir_dac_serializer #(
  parameter int N       = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 10,
  parameter int BIT_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                clk_d,
  input  logic signed [N-1:0] y_in,
  output logic                sclk,
  output logic                sdata,
  output logic                frame,
  output logic                busy,
  output logic                clip,
  output logic                overrun
);

  localparam int BC_W = $clog2(OUT_W);
  localparam int DC_W = $clog2(BIT_DIV);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(OUT_W - 1);
  localparam logic [DC_W-1:0] DIV_LAST = DC_W'(BIT_DIV - 1);
  localparam logic [DC_W-1:0] DIV_HALF = DC_W'(BIT_DIV / 2);

  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [N:0] RND = (SHIFT > 0) ? ((N + 1)'(1) << RND_SH) : '0;
  localparam logic [N:0] SAT_LIM = (N + 1)'(1) << (OUT_W - 1);
  localparam logic signed [N:0] SAT_MAX = SAT_LIM - (N + 1)'(1);
  localparam logic signed [N:0] SAT_MIN = -SAT_LIM;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  function automatic logic signed [N:0] round_shift(input logic signed [N-1:0] x);
    logic signed [N:0] s;
    s = {x[N-1], x} + RND;
    return s >>> SHIFT;
  endfunction

  function automatic logic out_of_range(input logic signed [N:0] r);
    return (r > SAT_MAX) || (r < SAT_MIN);
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic signed [N:0] r);
    if (r > SAT_MAX)
      return {1'b0, {(OUT_W - 1){1'b1}}};
    else if (r < SAT_MIN)
      return {1'b1, {(OUT_W - 1){1'b0}}};
    else
      return r[OUT_W-1:0];
  endfunction

  state_t                r_state;
  state_t                w_state_nx;
  logic                  r_clk_d_q;
  logic                  r_hold_valid;
  logic [OUT_W-1:0]      r_hold;
  logic [OUT_W-1:0]      r_shreg;
  logic [OUT_W-1:0]      w_shreg_nx;
  logic [BC_W-1:0]       r_bit_cnt;
  logic [BC_W-1:0]       w_bit_nx;
  logic [DC_W-1:0]       r_div_cnt;
  logic [DC_W-1:0]       w_div_nx;
  logic                  w_load;
  logic                  w_cap;
  logic signed [N:0]     w_scaled;
  logic                  w_sat;
  logic [OUT_W-1:0]      w_word;
  logic                  r_sclk;
  logic                  r_sdata;
  logic                  r_frame;
  logic                  r_busy;
  logic                  r_clip;
  logic                  r_overrun;
  logic                  w_sclk_nx;
  logic                  w_sdata_nx;
  logic                  w_frame_nx;
  logic                  w_busy_nx;

  assign w_cap    = clk_d & ~r_clk_d_q & ena;
  assign w_scaled = round_shift(y_in);
  assign w_sat    = out_of_range(w_scaled);
  assign w_word   = saturate(w_scaled);

  always_comb begin
    w_state_nx = r_state;
    w_shreg_nx = r_shreg;
    w_bit_nx   = r_bit_cnt;
    w_div_nx   = r_div_cnt;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_valid)
          w_state_nx = S_LOAD;
      end
      S_LOAD: begin
        w_load     = 1'b1;
        w_shreg_nx = r_hold;
        w_bit_nx   = '0;
        w_div_nx   = '0;
        w_state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_nx   = '0;
          w_shreg_nx = {r_shreg[OUT_W-2:0], 1'b0};
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_nx   = '0;
            w_state_nx = S_GAP;
          end else begin
            w_bit_nx = r_bit_cnt + 1'b1;
          end
        end else begin
          w_div_nx = r_div_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_nx   = '0;
          w_state_nx = r_hold_valid ? S_LOAD : S_IDLE;
        end else begin
          w_div_nx = r_div_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Line outputs are registered from the next-state view so they align with the bit counters.
  always_comb begin
    w_sdata_nx = 1'b0;
    w_sclk_nx  = 1'b0;
    w_frame_nx = 1'b0;
    w_busy_nx  = (w_state_nx != S_IDLE);
    if (w_state_nx == S_SHIFT) begin
      w_sdata_nx = w_shreg_nx[OUT_W-1];
      w_sclk_nx  = (w_div_nx >= DIV_HALF);
      w_frame_nx = (w_bit_nx == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_clk_d_q    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_sclk       <= 1'b0;
      r_sdata      <= 1'b0;
      r_frame      <= 1'b0;
      r_busy       <= 1'b0;
      r_clip       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_clk_d_q <= clk_d;
      r_bit_cnt <= w_bit_nx;
      r_div_cnt <= w_div_nx;
      r_sclk    <= w_sclk_nx;
      r_sdata   <= w_sdata_nx;
      r_frame   <= w_frame_nx;
      r_busy    <= w_busy_nx;
      r_clip    <= w_cap & w_sat;
      if (w_cap)
        r_hold_valid <= 1'b1;
      else if (w_load)
        r_hold_valid <= 1'b0;
      // A capture landing on a still-pending hold that LOAD is not taking this edge loses the older sample.
      if (w_cap && r_hold_valid && !w_load)
        r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap)
      r_hold <= w_word;
    r_shreg <= w_shreg_nx;
  end

  assign sclk    = r_sclk;
  assign sdata   = r_sdata;
  assign frame   = r_frame;
  assign busy    = r_busy;
  assign clip    = r_clip;
  assign overrun = r_overrun;

endmodule
